mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences the single-port main memory between the instruction-cache and data-cache miss handlers. Serves one requester at a time: either an 8-word block fill or a single-word write-through store. Streams fill words back to the granted cache and produces the stall signals that freeze the fetch stage and the memory/writeback pipeline registers while a request is outstanding. Sits between the two cache controllers and the 4-cycle pipelined memory model.

## Interface
- BLOCK_WORDS, 8, 16-bit words per cache block (power of two).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_miss  in  1  I-cache miss; level, held until `i_done`.
- i_addr  in  16  I-side byte address; block-aligned internally.
- d_miss  in  1  D-cache miss; level, held until `d_done`.
- d_wr  in  1  D-side store write-through; level, held until `d_done`.
- d_addr  in  16  D-side byte address.
- d_wdata  in  16  store data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  memory write enable; qualified by `mem_en`.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  `mem_rdata` valid; the memory pipeline returns reads in issue order.
- fill_we_i, fill_we_d  out  1 each  write one fill word into the I- or D-cache data array.
- fill_idx  out  3  word index of the current fill word within the block.
- fill_data  out  16  fill word; equals `mem_rdata`.
- i_done, d_done  out  1 each  one-cycle completion pulse.
- stall_if  out  1  freeze the fetch stage.
- stall_mem  out  1  freeze the memory/writeback register (its `wen` is `~stall_mem`).

## Operation
- **States:** IDLE, WRITE, FILL, DONE.
- **Leaving IDLE:**
  - If `d_miss` or `d_wr` is asserted and grant selects D, the FSM goes to WRITE if `d_wr` is set, otherwise to FILL.
  - If `i_miss` is asserted and grant selects I, the FSM goes to FILL.
  - `d_wr` and `d_miss` asserted together: the write is served first, then the miss.
- **Grant** is latched on leaving IDLE into `owner` (I/D). With both sides requesting, D wins (see Configuration).
- **WRITE** lasts one cycle:
  - Drives `mem_en=1`, `mem_wr=1`, `mem_addr=d_addr`, `mem_wdata=d_wdata`.
  - Next state is DONE.
- **FILL:**
  - `base = {addr[15:4], 4'b0}`.
  - An issue counter drives `mem_en=1`, `mem_wr=0`, `mem_addr = base + 2*iss` for `iss` = 0..7, one per cycle, with no gaps.
  - A receive counter `rcv` increments on each `mem_valid`. That cycle drives `fill_we_<owner>=1`, `fill_idx=rcv`, `fill_data=mem_rdata`.
  - After the `mem_valid` with `rcv==7`, next state is DONE.
  - `mem_valid` seen outside FILL is ignored.
- **DONE** lasts one cycle: pulses `<owner>_done`, clears the counters, returns to IDLE.
  - A request still asserted in IDLE is re-arbitrated on the following cycle. The requester deasserts in the cycle after `done`.
- **Stalls**, combinational:
  - `stall_if = i_miss & ~i_done`.
  - `stall_mem = (d_miss | d_wr) & ~d_done`.
- **Counter widths:** both counters are 3 bits; wrap from 7 to 0 is never used within one fill.
- **Reset, including mid-fill:**
  - FSM goes to IDLE; counters and `owner` clear.
  - All outputs are 0, and no `done` pulse is emitted.
  - Requesters re-request after reset.

## Timing
- Write-through: `d_wr` rises in cycle 0 → WRITE in cycle 1 → `d_done` in cycle 2 → `stall_mem` falls in cycle 2.
- Fill with 4-cycle memory latency:
  - Request in cycle 0.
  - Issues in cycles 1–8.
  - `fill_we` in cycles 5–12.
  - `done` in cycle 13.
  - The FSM is busy for 13 cycles, with IDLE available again in cycle 14.
- No new grant is made while in WRITE, FILL or DONE.
- **Registered outputs:**
  - `mem_en`, `mem_wr`, `mem_addr` and `mem_wdata` are driven from state and counter registers.
  - `done` is registered.

## Configuration
- `MEM_ARB_RR_EN`:
  - When defined, arbitration is round-robin: on a simultaneous I and D request, the side not granted last wins. `last_owner` resets to I, so D wins first.
  - When undefined, fixed priority: D always wins.

## Structure
- Package `wisc_mem_pkg` holds:
  - the state enum (IDLE, WRITE, FILL, DONE);
  - `BLOCK_WORDS`;
  - the block-offset width constant (4);
  - the owner encoding (`OWN_I=0`, `OWN_D=1`).
- One sub-module, `mem_fill_counter`: a 3-bit counter with enable, clear and terminal-count output. It is instantiated twice, for issue and for receive.

## Test plan
- Lone `i_miss`, `i_addr=0x1236` → reads issued to 0x1230..0x123E; `fill_we_i` with `fill_idx` 0..7 carrying `mem_rdata`; `i_done` in cycle 13; `stall_if` high in cycles 0–12.
- Lone `d_wr`, `d_addr=0x0040`, `d_wdata=0xBEEF` → one `mem_wr` cycle at 0x0040 with data 0xBEEF; `d_done` in cycle 2.
- `i_miss` and `d_miss` rise in the same cycle → D fill served first, then I fill; `i_done` occurs 14 cycles after `d_done`. With `MEM_ARB_RR_EN`, a second simultaneous pair serves I first.
- `d_wr` and `d_miss` together → write completes first, then the D fill; no `fill_we_i` at any point.
- `rst_n` driven low at the 5th `fill_we_d` → all outputs 0 immediately; no `d_done`; after release the request is served from word 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// wisc_mem_pkg: shared FSM states, block geometry and owner encoding for the memory arbiter.
package wisc_mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FILL, ST_DONE} state_e;
  localparam int BLOCK_WORDS = 8;
  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = 4;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [15:0] BASE_MASK = 16'hFFFF << OFF_W;
  // Byte address of word idx within the block holding address a.
  function automatic logic [15:0] word_addr(input logic [15:0] a, input logic [CNT_W-1:0] idx);
    return (a & BASE_MASK) | {{(16-CNT_W-1){1'b0}}, idx, 1'b0};
  endfunction
endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// mem_fill_counter: block word counter with enable, clear and terminal count.
module mem_fill_counter
  import wisc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
  assign tc_o = cnt_q == CNT_W'(BLOCK_WORDS - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I/D block fills and D write-throughs onto one memory port.
// Define MEM_ARB_RR_EN for round-robin on contested grants; default is fixed D priority.
module mem_arbiter
  import wisc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_miss,
  input  logic [15:0]      i_addr,
  input  logic             d_miss,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_valid,
  output logic             fill_we_i,
  output logic             fill_we_d,
  output logic [CNT_W-1:0] fill_idx,
  output logic [15:0]      fill_data,
  output logic             i_done,
  output logic             d_done,
  output logic             stall_if,
  output logic             stall_mem
);
  state_e state_q, state_d;
  logic owner_q, owner_d, issued_q, issued_d;
  logic d_req, pick_d, fill, wr_st, done_st, iss_en, rcv_en, iss_tc, rcv_tc;
  logic [CNT_W-1:0] iss, rcv;
  logic [15:0] req_addr;
  assign d_req = d_miss | d_wr;
`ifdef MEM_ARB_RR_EN
  logic last_q;
  assign pick_d = d_req & (~i_miss | (last_q == OWN_I));
  // Only contested grants move the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= OWN_I;
    else if (state_q == ST_IDLE && d_req && i_miss) last_q <= pick_d ? OWN_D : OWN_I;
`else
  assign pick_d = d_req;
`endif
  assign fill = state_q == ST_FILL;
  assign wr_st = state_q == ST_WRITE;
  assign done_st = state_q == ST_DONE;
  assign iss_en = fill & ~issued_q;
  assign rcv_en = fill & mem_valid;
  mem_fill_counter u_iss (.clk, .rst_n, .en_i(iss_en & ~iss_tc), .clr_i(done_st), .cnt_o(iss), .tc_o(iss_tc));
  mem_fill_counter u_rcv (.clk, .rst_n, .en_i(rcv_en & ~rcv_tc), .clr_i(done_st), .cnt_o(rcv), .tc_o(rcv_tc));
  assign issued_d = done_st ? 1'b0 : (issued_q | (iss_en & iss_tc));
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: if (d_req || i_miss) begin
        owner_d = pick_d ? OWN_D : OWN_I;
        state_d = (pick_d && d_wr) ? ST_WRITE : ST_FILL;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_FILL: state_d = (rcv_en && rcv_tc) ? ST_DONE : ST_FILL;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      issued_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      issued_q <= issued_d;
    end
  assign req_addr = (owner_q == OWN_D) ? d_addr : i_addr;
  assign mem_en = wr_st | iss_en;
  assign mem_wr = wr_st;
  assign mem_addr = wr_st ? d_addr : iss_en ? word_addr(req_addr, iss) : '0;
  assign mem_wdata = wr_st ? d_wdata : '0;
  assign fill_we_i = rcv_en & (owner_q == OWN_I);
  assign fill_we_d = rcv_en & (owner_q == OWN_D);
  assign fill_idx = rcv_en ? rcv : '0;
  assign fill_data = rcv_en ? mem_rdata : '0;
  assign i_done = done_st & (owner_q == OWN_I);
  assign d_done = done_st & (owner_q == OWN_D);
  // Stalls are forced low while reset is held so every output reads 0.
  assign stall_if = rst_n & i_miss & ~i_done;
  assign stall_mem = rst_n & d_req & ~d_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a 4-cycle pipelined memory model.
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_miss = 0, d_miss = 0, d_wr = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic mem_en, mem_wr, mem_valid, fill_we_i, fill_we_d, i_done, d_done, stall_if, stall_mem;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0] fill_idx;
  logic [7:0] ctl;
  logic [3:0] pv;
  logic [15:0] pa [4];
  int tests = 0, fails = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .fill_we_i(fill_we_i),
    .fill_we_d(fill_we_d), .fill_idx(fill_idx), .fill_data(fill_data), .i_done(i_done),
    .d_done(d_done), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pv <= '0;
    else begin
      pv <= {pv[2:0], mem_en & ~mem_wr};
      pa[0] <= mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  assign mem_valid = pv[3];
  assign mem_rdata = pv[3] ? (pa[3] ^ 16'hA5A5) : 16'h0;
  assign ctl = {mem_en, mem_wr, fill_we_i, fill_we_d, i_done, d_done, stall_if, stall_mem};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected control vector j cycles after a fill request was sampled.
  function automatic logic [7:0] fill_ctl(int j, logic own, logic si, logic sm);
    logic en, fw, dn;
    en = j >= 1 && j <= 8;
    fw = j >= 5 && j <= 12;
    dn = j == 13;
    return {en, 1'b0, fw & ~own, fw & own, dn & ~own, dn & own, si, sm};
  endfunction

  task automatic test_reset();
    i_miss = 1; d_wr = 1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ctl, mem_addr, mem_wdata, fill_idx, fill_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h idx=%0d data=%h, need all 0", ctl, mem_addr, mem_wdata, fill_idx, fill_data);
    end
    i_miss = 0; d_wr = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
    tests++;
    if (ctl !== 8'h00) begin fails++; $display("FAIL idle_after_reset: ctl=%b, need 00000000", ctl); end
  endtask

  task automatic test_i_fill();
    i_addr = 16'h1236; i_miss = 1; #1;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) tick();
      tests++;
      if (ctl !== fill_ctl(k, 1'b0, k <= 12, 1'b0)) begin
        fails++; $display("FAIL i_fill_ctl c%0d: ctl=%b, need %b", k, ctl, fill_ctl(k, 1'b0, k <= 12, 1'b0));
      end
      if (k >= 1 && k <= 8) begin
        tests++;
        if (mem_addr !== 16'(16'h1230 + 2 * (k - 1))) begin
          fails++; $display("FAIL i_fill_addr c%0d: addr=%h, need %h", k, mem_addr, 16'(16'h1230 + 2 * (k - 1)));
        end
      end
      if (k >= 5 && k <= 12) begin
        tests++;
        if ({fill_idx, fill_data} !== {3'(k - 5), 16'(16'h1230 + 2 * (k - 5)) ^ 16'hA5A5}) begin
          fails++; $display("FAIL i_fill_word c%0d: idx=%0d data=%h, need idx=%0d data=%h", k, fill_idx, fill_data, k - 5, 16'(16'h1230 + 2 * (k - 5)) ^ 16'hA5A5);
        end
      end
    end
    tick(); i_miss = 0; #1;
    tests++;
    if (ctl !== 8'h00) begin fails++; $display("FAIL i_fill_release: ctl=%b, need 00000000", ctl); end
  endtask

  task automatic test_write();
    d_addr = 16'h0040; d_wdata = 16'hBEEF; d_wr = 1; #1;
    tests++;
    if (ctl !== 8'b00000001) begin fails++; $display("FAIL write_c0: ctl=%b, need 00000001", ctl); end
    tick();
    tests++;
    if ({ctl, mem_addr, mem_wdata} !== {8'b11000001, 16'h0040, 16'hBEEF}) begin
      fails++; $display("FAIL write_c1: ctl=%b addr=%h wdata=%h, need 11000001 0040 beef", ctl, mem_addr, mem_wdata);
    end
    tick();
    tests++;
    if (ctl !== 8'b00000100) begin fails++; $display("FAIL write_done_c2: ctl=%b, need 00000100", ctl); end
    tick(); d_wr = 0; #1;
    tests++;
    if (ctl !== 8'h00) begin fails++; $display("FAIL write_release: ctl=%b, need 00000000", ctl); end
  endtask

  task automatic test_both_miss(input logic d_first);
    logic own;
    int j;
    logic [15:0] base;
    i_addr = 16'h2004; d_addr = 16'h3008; i_miss = 1; d_miss = 1; #1;
    for (int k = 0; k <= 27; k++) begin
      if (k > 0) tick();
      if (k == 14) begin
        if (d_first) d_miss = 0; else i_miss = 0;
        #1;
      end
      own = (k <= 13) ? d_first : ~d_first;
      j = (k <= 13) ? k : k - 14;
      base = own ? 16'h3000 : 16'h2000;
      tests++;
      if (ctl !== fill_ctl(j, own, d_first ? k <= 26 : k <= 12, d_first ? k <= 12 : k <= 26)) begin
        fails++; $display("FAIL both_ctl c%0d: ctl=%b, need %b", k, ctl, fill_ctl(j, own, d_first ? k <= 26 : k <= 12, d_first ? k <= 12 : k <= 26));
      end
      if (j >= 1 && j <= 8) begin
        tests++;
        if (mem_addr !== 16'(base + 2 * (j - 1))) begin
          fails++; $display("FAIL both_addr c%0d: addr=%h, need %h", k, mem_addr, 16'(base + 2 * (j - 1)));
        end
      end
      if (j >= 5 && j <= 12) begin
        tests++;
        if ({fill_idx, fill_data} !== {3'(j - 5), 16'(base + 2 * (j - 5)) ^ 16'hA5A5}) begin
          fails++; $display("FAIL both_word c%0d: idx=%0d data=%h", k, fill_idx, fill_data);
        end
      end
    end
    tick(); i_miss = 0; d_miss = 0; #1;
    tests++;
    if (ctl !== 8'h00) begin fails++; $display("FAIL both_release: ctl=%b, need 00000000", ctl); end
  endtask

  task automatic test_wr_miss();
    d_addr = 16'h0456; d_wdata = 16'h1234; d_wr = 1; d_miss = 1; #1;
    tests++;
    if (ctl !== 8'b00000001) begin fails++; $display("FAIL wrmiss_c0: ctl=%b, need 00000001", ctl); end
    tick();
    tests++;
    if ({ctl, mem_addr, mem_wdata} !== {8'b11000001, 16'h0456, 16'h1234}) begin
      fails++; $display("FAIL wrmiss_write: ctl=%b addr=%h wdata=%h, need 11000001 0456 1234", ctl, mem_addr, mem_wdata);
    end
    tick();
    tests++;
    if (ctl !== 8'b00000100) begin fails++; $display("FAIL wrmiss_wdone: ctl=%b, need 00000100", ctl); end
    for (int k = 3; k <= 16; k++) begin
      tick();
      if (k == 3) begin d_wr = 0; #1; end
      tests++;
      if (ctl !== fill_ctl(k - 3, 1'b1, 1'b0, k <= 15)) begin
        fails++; $display("FAIL wrmiss_fill c%0d: ctl=%b, need %b", k, ctl, fill_ctl(k - 3, 1'b1, 1'b0, k <= 15));
      end
      if (k - 3 >= 1 && k - 3 <= 8) begin
        tests++;
        if (mem_addr !== 16'(16'h0450 + 2 * (k - 4))) begin
          fails++; $display("FAIL wrmiss_addr c%0d: addr=%h, need %h", k, mem_addr, 16'(16'h0450 + 2 * (k - 4)));
        end
      end
    end
    tick(); d_miss = 0; #1;
    tests++;
    if (ctl !== 8'h00) begin fails++; $display("FAIL wrmiss_release: ctl=%b, need 00000000", ctl); end
  endtask

  task automatic test_reset_mid_fill();
    d_addr = 16'h0800; d_miss = 1; #1;
    repeat (9) tick();
    tests++;
    if ({fill_we_d, fill_idx} !== {1'b1, 3'd4}) begin
      fails++; $display("FAIL midrst_fifth_word: we_d=%b idx=%0d, need 1 4", fill_we_d, fill_idx);
    end
    rst_n = 0; #1;
    tests++;
    if ({ctl, mem_addr, mem_wdata, fill_idx, fill_data} !== '0) begin
      fails++; $display("FAIL midrst_outputs: ctl=%b addr=%h wdata=%h idx=%0d data=%h, need all 0", ctl, mem_addr, mem_wdata, fill_idx, fill_data);
    end
    repeat (2) begin
      tick();
      tests++;
      if (ctl !== 8'h00) begin fails++; $display("FAIL midrst_held: ctl=%b, need 00000000", ctl); end
    end
    #2 rst_n = 1; #1;
    for (int j = 1; j <= 13; j++) begin
      tick();
      tests++;
      if (ctl !== fill_ctl(j, 1'b1, 1'b0, j <= 12)) begin
        fails++; $display("FAIL midrst_refill c%0d: ctl=%b, need %b", j, ctl, fill_ctl(j, 1'b1, 1'b0, j <= 12));
      end
      if (j >= 1 && j <= 8) begin
        tests++;
        if (mem_addr !== 16'(16'h0800 + 2 * (j - 1))) begin
          fails++; $display("FAIL midrst_addr c%0d: addr=%h, need %h", j, mem_addr, 16'(16'h0800 + 2 * (j - 1)));
        end
      end
      if (j >= 5 && j <= 12) begin
        tests++;
        if (fill_idx !== 3'(j - 5)) begin fails++; $display("FAIL midrst_idx c%0d: idx=%0d, need %0d", j, fill_idx, j - 5); end
      end
    end
    tick(); d_miss = 0; #1;
    tests++;
    if (ctl !== 8'h00) begin fails++; $display("FAIL midrst_release: ctl=%b, need 00000000", ctl); end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_write();
    test_both_miss(1'b1);
`ifdef MEM_ARB_RR_EN
    test_both_miss(1'b0);
`else
    test_both_miss(1'b1);
`endif
    test_wr_miss();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
